ring_inject_arbiter: RTL and testbench
======================================

RING_INJECT_ARBITER -- requirements
Module: ring_inject_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing one router injection port (2..16).
REQ-002 SHALL have parameter DEST_WIDTH, default 6, meaning the destination field width.
REQ-003 SHALL have parameter FLIT_WIDTH, default 128, meaning the flit payload width.
REQ-004 SHALL have parameter FLIT_BUFFER_DEPTH, default 4, meaning the downstream router input buffer depth, which is the initial credit count.
REQ-005 SHALL have: clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have: rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have: valid_in  input  [NUM_REQ] (unpacked)  per-requester flit valid.
REQ-008 SHALL have: ready_out  output  [NUM_REQ] (unpacked)  per-requester flit accept.
REQ-009 SHALL have: data_in / dest_in / is_tail_in  input  FLIT_WIDTH / DEST_WIDTH / 1 per requester (unpacked)  flit payload, destination, last-flit marker.
REQ-010 SHALL have: data_out / dest_out / is_tail_out  output  FLIT_WIDTH / DEST_WIDTH / 1  registered flit to the router.
REQ-011 SHALL have: send_out  output  1  one-cycle pulse per flit delivered.
REQ-012 SHALL have: credit_in  input  1  one-cycle pulse returning one buffer slot.

Function
REQ-013 SHALL accept a flit from requester i in a cycle exactly when valid_in[i] and ready_out[i] are both 1.
REQ-014 SHALL drive send_out=1 with the accepted flit on data_out/dest_out/is_tail_out in the cycle after acceptance (latency 1), and send_out=0 otherwise.
REQ-015 SHALL hold data_out/dest_out/is_tail_out unchanged when send_out=0.
REQ-016 SHALL keep a credit counter of width $clog2(FLIT_BUFFER_DEPTH+1), decremented on acceptance and incremented on credit_in; both in one cycle leave it unchanged.
REQ-017 SHALL drive all ready_out to 0 while the credit counter is 0.
REQ-018 SHALL saturate the counter at FLIT_BUFFER_DEPTH when credit_in arrives at maximum, and flag it with a simulation-only assertion.
REQ-019 SHALL implement FSM states IDLE and LOCKED, with a LOCKED owner register.
REQ-020 In IDLE with credit>0, SHALL grant the valid requester found first when searching upward from rr_ptr with wrap-around, and raise only that ready_out in the same cycle.
REQ-021 SHALL move IDLE->LOCKED (owner=winner) when the accepted flit has is_tail_in=0; a single-flit packet leaves the state in IDLE.
REQ-022 In LOCKED, SHALL assert only ready_out[owner] (when credit>0), ignoring other requesters, until the tail flit is accepted, then go to IDLE.
REQ-023 SHALL set rr_ptr to (winner+1) mod NUM_REQ on every tail-flit acceptance and leave it unchanged otherwise.
REQ-024 SHALL never interleave flits of different packets on the output.
REQ-025 SHALL require no valid_in to ready_out dependency other than the combinational grant; requesters may not drop valid_in or change payload before acceptance.

Reset
REQ-026 On rst_n=0 at a clock edge, SHALL set state=IDLE, owner=0, rr_ptr=0, credit=FLIT_BUFFER_DEPTH, send_out=0, is_tail_out=0, data_out=0, dest_out=0.
REQ-027 While rst_n=0, SHALL drive all ready_out to 0; a packet that is mid-flight when reset asserts is abandoned.

Configuration
REQ-028 With RING_INJECT_ARB_STATS_EN defined, SHALL add an output pkt_count [NUM_REQ] x 32 (unpacked), counting tail acceptances per requester, saturating at 2^32-1 and reset to 0.
REQ-029 Without RING_INJECT_ARB_STATS_EN, SHALL omit the pkt_count port and its counters; all other behaviour is identical.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, LOCKED) and the credit-width helper function in package ring_arb_pkg.
REQ-031 SHALL implement the rotating-priority search as sub-module rr_priority_select (request vector + pointer in, one-hot grant + index out; purely combinational).

Verification (NUM_REQ=4, FLIT_BUFFER_DEPTH=4)
REQ-032 After reset, requesters 0..3 each send a 1-flit packet continuously, credit_in returned 2 cycles after each send_out -> grants in order 0,1,2,3,0,...
REQ-033 Requester 1 sends a 3-flit packet while requester 2 is valid -> three consecutive send_out from 1 (tail on the third), then requester 2 is granted.
REQ-034 No credit_in is returned -> exactly 4 send_out pulses, then all ready_out are 0; a single credit_in pulse -> exactly one further flit.
REQ-035 credit_in and an acceptance occur in the same cycle while credit=2 -> credit stays 2.
REQ-036 rst_n is pulsed low after flit 2 of a 4-flit packet from requester 3 -> next cycle: send_out=0, credit=4, state IDLE; requester 0 (now valid) is granted first.
REQ-037 With RING_INJECT_ARB_STATS_EN defined, 5 packets from requester 2 -> pkt_count[2]=5 and all other counts are 0.

Source files
------------

// File: rtl/ring_inject_arbiter_pkg.sv
// Shared types and helpers for the ring injection arbiter.
// Optional statistics counters are enabled with RING_INJECT_ARB_STATS_EN.
package ring_arb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Bits needed to hold a credit count from 0 up to the buffer depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ring_inject_arbiter_chk.sv
// Simulation checker for the injection arbiter credit counter.
// Flags a credit return arriving while the counter is already full.
module ring_inject_arbiter_chk #(
    parameter int              CREDIT_W   = 3,
    parameter logic [CREDIT_W-1:0] CREDIT_MAX = 3'd4
) (
    input logic                clk,
    input logic                rst_n,
    input logic [CREDIT_W-1:0] credit,
    input logic                credit_in,
    input logic                accept
);

    a_credit_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(credit_in && !accept && (credit == CREDIT_MAX))
    );

endmodule

// File: rtl/ring_inject_arbiter_rr.sv
// Rotating-priority search: first set request at or above ptr, wrapping around.
// Purely combinational; grant is one-hot (all zero when nothing requests).
module rr_priority_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(N);

    logic             found_s;
    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Walk the requesters starting at ptr and keep the first one found.
    always_comb begin
        found_s = 1'b0;
        idx     = {IDX_W{1'b0}};
        grant   = {N{1'b0}};
        sum_s   = {(IDX_W + 1){1'b0}};
        cand_s  = {IDX_W{1'b0}};
        for (int off = 0; off < N; off++) begin
            sum_s = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (sum_s >= N_L) begin
                cand_s = IDX_W'(sum_s - N_L);
            end else begin
                cand_s = sum_s[IDX_W-1:0];
            end
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                idx     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            grant[idx] = 1'b1;
        end else begin
            grant = {N{1'b0}};
        end
    end

endmodule

// File: rtl/ring_inject_arbiter.sv
// Wormhole injection arbiter: NUM_REQ requesters share one credit-controlled router port.
// Define RING_INJECT_ARB_STATS_EN to add per-requester packet counters (pkt_count).
module ring_inject_arbiter
    import ring_arb_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_WIDTH        = 128,
    parameter int FLIT_BUFFER_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in    [NUM_REQ],
    output logic                  ready_out   [NUM_REQ],
    input  logic [FLIT_WIDTH-1:0] data_in     [NUM_REQ],
    input  logic [DEST_WIDTH-1:0] dest_in     [NUM_REQ],
    input  logic                  is_tail_in  [NUM_REQ],
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in
`ifdef RING_INJECT_ARB_STATS_EN
    ,
    output logic [31:0]           pkt_count   [NUM_REQ]
`endif
);

    localparam int                  IDX_W      = $clog2(NUM_REQ);
    localparam int                  CREDIT_W   = credit_width(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_r, state_nxt_s;
    logic [IDX_W-1:0]    owner_r, owner_nxt_s;
    logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
    logic [CREDIT_W-1:0] credit_r, credit_nxt_s;

    logic [NUM_REQ-1:0]  valid_vec_s;
    logic [NUM_REQ-1:0]  ready_vec_s;
    logic [NUM_REQ-1:0]  rr_grant_s;
    logic [IDX_W-1:0]    rr_idx_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic                accept_s;
    logic                win_tail_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
        assign valid_vec_s[g] = valid_in[g];
        assign ready_out[g]   = ready_vec_s[g];
    end

    rr_priority_select #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (valid_vec_s),
        .ptr   (rr_ptr_r),
        .grant (rr_grant_s),
        .idx   (rr_idx_s)
    );

    // Grant selection, acceptance and next-state for FSM, pointer and credits.
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        rr_ptr_nxt_s = rr_ptr_r;
        credit_nxt_s = credit_r;
        ready_vec_s  = {NUM_REQ{1'b0}};
        win_idx_s    = rr_idx_s;

        // In LOCKED the owner is offered the port even before it presents its next flit.
        if (rst_n && (credit_r != {CREDIT_W{1'b0}})) begin
            case (state_r)
                IDLE: begin
                    win_idx_s   = rr_idx_s;
                    ready_vec_s = rr_grant_s;
                end
                LOCKED: begin
                    win_idx_s             = owner_r;
                    ready_vec_s[owner_r]  = 1'b1;
                end
                default: begin
                    ready_vec_s = {NUM_REQ{1'b0}};
                end
            endcase
        end else begin
            ready_vec_s = {NUM_REQ{1'b0}};
        end

        accept_s   = valid_vec_s[win_idx_s] & ready_vec_s[win_idx_s];
        win_tail_s = is_tail_in[win_idx_s];

        if (accept_s && win_tail_s) begin
            state_nxt_s  = IDLE;
            rr_ptr_nxt_s = (win_idx_s == IDX_LAST) ? {IDX_W{1'b0}} : win_idx_s + IDX_W'(1);
        end else if (accept_s) begin
            state_nxt_s = LOCKED;
            owner_nxt_s = win_idx_s;
        end else begin
            state_nxt_s = state_r;
        end

        case ({accept_s, credit_in})
            2'b10:   credit_nxt_s = credit_r - CREDIT_W'(1);
            2'b01:   credit_nxt_s = (credit_r == CREDIT_MAX) ? credit_r : credit_r + CREDIT_W'(1);
            default: credit_nxt_s = credit_r;
        endcase
    end

    // Control state: FSM, packet owner, round-robin pointer and credit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            owner_r  <= {IDX_W{1'b0}};
            rr_ptr_r <= {IDX_W{1'b0}};
            credit_r <= CREDIT_MAX;
        end else begin
            state_r  <= state_nxt_s;
            owner_r  <= owner_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            credit_r <= credit_nxt_s;
        end
    end

    // Output flit register; payload holds its last value between sends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            send_out    <= 1'b0;
            is_tail_out <= 1'b0;
            data_out    <= {FLIT_WIDTH{1'b0}};
            dest_out    <= {DEST_WIDTH{1'b0}};
        end else if (accept_s) begin
            send_out    <= 1'b1;
            is_tail_out <= win_tail_s;
            data_out    <= data_in[win_idx_s];
            dest_out    <= dest_in[win_idx_s];
        end else begin
            send_out    <= 1'b0;
        end
    end

`ifdef RING_INJECT_ARB_STATS_EN
    logic [31:0] pkt_cnt_r [NUM_REQ];

    // Per-requester completed-packet counters, saturating at all ones.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                pkt_cnt_r[i] <= 32'd0;
            end else if (accept_s && win_tail_s && (win_idx_s == IDX_W'(i))
                         && (pkt_cnt_r[i] != 32'hFFFF_FFFF)) begin
                pkt_cnt_r[i] <= pkt_cnt_r[i] + 32'd1;
            end else begin
                pkt_cnt_r[i] <= pkt_cnt_r[i];
            end
        end
    end

    assign pkt_count = pkt_cnt_r;
`endif

    ring_inject_arbiter_chk #(
        .CREDIT_W   (CREDIT_W),
        .CREDIT_MAX (CREDIT_MAX)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .credit    (credit_r),
        .credit_in (credit_in),
        .accept    (accept_s)
    );

endmodule

// File: tb/tb_ring_inject_arbiter.sv
// Directed self-checking bench for ring_inject_arbiter (NUM_REQ=4, FLIT_BUFFER_DEPTH=4).
// Stats checks run only when RING_INJECT_ARB_STATS_EN is defined.
module tb_ring_inject_arbiter;
    import ring_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 6;
    localparam int FW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in    [N];
    logic          ready_out   [N];
    logic [FW-1:0] data_in     [N];
    logic [DW-1:0] dest_in     [N];
    logic          is_tail_in  [N];
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in;
`ifdef RING_INJECT_ARB_STATS_EN
    logic [31:0]   pkt_count   [N];
`endif

    ring_inject_arbiter #(
        .NUM_REQ           (N),
        .DEST_WIDTH        (DW),
        .FLIT_WIDTH        (FW),
        .FLIT_BUFFER_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_in     (data_in),
        .dest_in     (dest_in),
        .is_tail_in  (is_tail_in),
        .data_out    (data_out),
        .dest_out    (dest_out),
        .is_tail_out (is_tail_out),
        .send_out    (send_out),
        .credit_in   (credit_in)
`ifdef RING_INJECT_ARB_STATS_EN
        ,
        .pkt_count   (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic [3:0] tail;
        logic       cin;
        logic [3:0] ready;
        logic       send;
        logic [5:0] dest;
        logic       tail_o;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] payload(input int i);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(i);
        return {4{w}};
    endfunction

    function automatic logic [127:0] exp_data(input logic [5:0] d);
        if (d == 6'd0) return 128'd0;
        return payload(int'(d) - 16);
    endfunction

    function automatic logic [3:0] ready_vec();
        logic [3:0] r;
        for (int i = 0; i < N; i++) r[i] = ready_out[i];
        return r;
    endfunction

    function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] t,
                                input logic c, input logic [3:0] rdy, input logic s,
                                input logic [5:0] d, input logic to);
        vec_t e;
        e.rst_n = r; e.valid = v; e.tail = t; e.cin = c;
        e.ready = rdy; e.send = s; e.dest = d; e.tail_o = to;
        vecs.push_back(e);
    endfunction

    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] t, input logic c);
        rst_n     = r;
        credit_in = c;
        for (int i = 0; i < N; i++) begin
            valid_in[i]   = v[i];
            is_tail_in[i] = t[i];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < N; i++) begin
            data_in[i] = payload(i);
            dest_in[i] = 6'(16 + i);
        end

        // Round robin over single-flit packets with credits coming back two cycles after send.
        add(1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 6'd0,  1'b0);
        add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 6'd16, 1'b1);
        add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 6'd17, 1'b1);
        add(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 6'd18, 1'b1);
        add(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 6'd19, 1'b1);
        add(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 6'd16, 1'b1);
        add(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 6'd17, 1'b1);
        add(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 6'd18, 1'b1);
        add(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 6'd19, 1'b1);
        add(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b1, 6'd17, 1'b1);
        add(1'b1, 4'b1010, 4'b1111, 1'b1, 4'b1000, 1'b1, 6'd19, 1'b1);
        add(1'b1, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 6'd19, 1'b1);
        // Three-flit packet from requester 1 locks out requester 2 until the tail.
        add(1'b0, 4'b0110, 4'b0100, 1'b0, 4'b0000, 1'b0, 6'd0,  1'b0);
        add(1'b1, 4'b0110, 4'b0100, 1'b0, 4'b0010, 1'b1, 6'd17, 1'b0);
        add(1'b1, 4'b0110, 4'b0100, 1'b0, 4'b0010, 1'b1, 6'd17, 1'b0);
        add(1'b1, 4'b0110, 4'b0110, 1'b0, 4'b0010, 1'b1, 6'd17, 1'b1);
        add(1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 6'd18, 1'b1);
        add(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 6'd18, 1'b1);
        // Credit exhaustion, then a single returned credit allows one more flit.
        add(1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 6'd0,  1'b0);
        for (int k = 0; k < 4; k++)
            add(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 6'd16, 1'b1);
        add(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 6'd16, 1'b1);
        add(1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 6'd16, 1'b1);
        add(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 6'd16, 1'b1);
        add(1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 6'd16, 1'b1);

        cyc();
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].rst_n, vecs[k].valid, vecs[k].tail, vecs[k].cin);
            #1;
            check($sformatf("row%0d ready", k), ready_vec(), vecs[k].ready);
            cyc();
            check($sformatf("row%0d send", k), send_out, vecs[k].send);
            check($sformatf("row%0d dest", k), dest_out, vecs[k].dest);
            check($sformatf("row%0d tail", k), is_tail_out, vecs[k].tail_o);
            check($sformatf("row%0d data", k), data_out, exp_data(vecs[k].dest));
        end

        // Simultaneous credit return and acceptance leave the counter unchanged.
        drive(1'b0, 4'b0000, 4'b0000, 1'b0); cyc();
        drive(1'b1, 4'b0001, 4'b0001, 1'b0); cyc(); cyc();
        check("credit_before", dut.credit_r, 128'd2);
        drive(1'b1, 4'b0001, 4'b0001, 1'b1);
        #1;
        check("credit_same_ready", ready_vec(), 128'h1);
        cyc();
        check("credit_same_send", send_out, 128'd1);
        check("credit_same", dut.credit_r, 128'd2);
        drive(1'b1, 4'b0000, 4'b0000, 1'b1); cyc();
        check("credit_inc", dut.credit_r, 128'd3);

        // Reset in the middle of a four-flit packet abandons it.
        drive(1'b0, 4'b0000, 4'b0000, 1'b0); cyc();
        drive(1'b1, 4'b1000, 4'b0000, 1'b0); cyc(); cyc();
        check("mid_state", dut.state_r, 128'(LOCKED));
        check("mid_dest", dest_out, 128'd19);
        drive(1'b0, 4'b1001, 4'b0000, 1'b0);
        #1;
        check("rst_ready", ready_vec(), 128'd0);
        cyc();
        check("rst_send", send_out, 128'd0);
        check("rst_credit", dut.credit_r, 128'd4);
        check("rst_state", dut.state_r, 128'(IDLE));
        check("rst_dest", dest_out, 128'd0);
        drive(1'b1, 4'b1001, 4'b0001, 1'b0);
        #1;
        check("post_rst_ready", ready_vec(), 128'h1);
        cyc();
        check("post_rst_send", send_out, 128'd1);
        check("post_rst_dest", dest_out, 128'd16);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0); cyc();

`ifdef RING_INJECT_ARB_STATS_EN
        // Five single-flit packets from requester 2.
        drive(1'b0, 4'b0000, 4'b0000, 1'b0); cyc();
        drive(1'b1, 4'b0100, 4'b0100, 1'b0); cyc();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b0100, 4'b0100, 1'b1); cyc();
        end
        drive(1'b1, 4'b0000, 4'b0000, 1'b0); cyc();
        for (int i = 0; i < N; i++)
            check($sformatf("pkt_count%0d", i), pkt_count[i], (i == 2) ? 128'd5 : 128'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
